// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with return-address stack
// Optional misaligned-redirect trap: define PCGEN_MISALIGN_TRAP_EN.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             trap,
  input  logic             jalr,
  input  logic [WIDTH-1:0] jalr_base,
  input  logic [WIDTH-1:0] jalr_imm,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_imm,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_push_addr,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    tp_q, tp_n, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             empty_q, full_q;
  logic             wr_en;
  logic             pop_ok;
  logic             redir;
  logic             bad;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] jalr_sum;

  assign pop_ok   = ras_pop && (cnt_q != '0);
  assign jalr_sum = jalr_base + jalr_imm;
  assign pc       = pc_q;
  assign pc_plus  = pc_q + WIDTH'(INC);
  assign ras_empty = empty_q;
  assign ras_full  = full_q;

  // Redirect target selection (rules below trap), then final next-PC priority
  always_comb begin
    redir = 1'b0;
    tgt   = '0;
    if (jalr) begin
      redir = 1'b1;
      tgt   = jalr_sum & ~WIDTH'(1);
    end else if (br_taken) begin
      redir = 1'b1;
      tgt   = br_pc + br_imm;
    end else if (pop_ok) begin
      redir = 1'b1;
      tgt   = ras_mem[tp_q];
    end

`ifdef PCGEN_MISALIGN_TRAP_EN
    bad = redir && ((tgt & WIDTH'(INC - 1)) != '0);
`else
    bad = 1'b0;
`endif

    if (trap || bad)  pc_n = TRAP_VECTOR;
    else if (redir)   pc_n = tgt;
    else if (stall)   pc_n = pc_q;
    else              pc_n = pc_q + WIDTH'(INC);
  end

  // RAS bookkeeping; a simultaneous push+pop replaces the top in place
  always_comb begin
    tp_n   = tp_q;
    cnt_n  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (ras_push && pop_ok) begin
      wr_en = 1'b1;
    end else if (ras_push) begin
      wr_en  = 1'b1;
      wr_idx = tp_q + PW'(1);
      tp_n   = tp_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) cnt_n = cnt_q + CW'(1);
    end else if (pop_ok) begin
      tp_n  = tp_q - PW'(1);
      cnt_n = cnt_q - CW'(1);
    end
    if (trap) begin
      wr_en = 1'b0;
      tp_n  = tp_q;
      cnt_n = '0;
    end else if (bad) begin
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      tp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_n;
      tp_q    <= tp_n;
      cnt_q   <= cnt_n;
      empty_q <= (cnt_n == '0);
      full_q  <= (cnt_n == CW'(RAS_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) ras_mem[wr_idx] <= ras_push_addr;
  end

`ifdef PCGEN_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= bad && !trap;
  end
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule
